// File: rtl/flag_period_mon.sv
// flag_period_mon: measures clocks between successive single-cycle flags, locks
// after LOCK_CNT consecutive correct periods, reports mismatches and timeouts.
// Ports: clk, rst (async, active-high), pi_flag in; period/period_vld,
// locked, err, to_err out. All outputs registered; latency 1 from the flag.
module flag_period_mon #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 4,
  parameter int LOCK_CNT   = 3,
  parameter int TIMEOUT    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pi_flag,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             err,
  output logic             to_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] EXP_P  = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TO_P   = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_N = 4'(LOCK_CNT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       good_cnt;

  // cnt holds the number of clocks since the last flag, so in a flag cycle
  // it is directly the measured period.
  logic period_ok;
  logic lock_next;
  logic timeout_hit;

  assign period_ok   = (cnt == EXP_P);
  assign lock_next   = ((good_cnt + 4'd1) == LOCK_N);
  // A flag in the timeout cycle wins: it is measured, not timed out.
  assign timeout_hit = (cnt == TO_P) && !pi_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      good_cnt   <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      to_err     <= 1'b0;
    end else begin
      // Pulse outputs default low; period and locked hold.
      period_vld <= 1'b0;
      err        <= 1'b0;
      to_err     <= 1'b0;

      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (pi_flag) begin
            // First flag only sets the reference; nothing to measure yet.
            // Loading 1 keeps the next measurement aligned with the flag.
            state    <= ACQ;
            good_cnt <= '0;
            cnt      <= CNT_W'(1);
          end
        end

        ACQ: begin
          if (pi_flag) begin
            cnt        <= CNT_W'(1);
            period     <= cnt;
            period_vld <= 1'b1;
            if (period_ok) begin
              if (lock_next) begin
                state    <= LOCK;
                locked   <= 1'b1;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + 4'd1;
              end
            end else begin
              // Wrong period: this flag becomes the new reference.
              err      <= 1'b1;
              good_cnt <= '0;
            end
          end else if (timeout_hit) begin
            to_err   <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            good_cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        LOCK: begin
          if (pi_flag) begin
            cnt        <= CNT_W'(1);
            period     <= cnt;
            period_vld <= 1'b1;
            if (!period_ok) begin
              err      <= 1'b1;
              locked   <= 1'b0;
              state    <= ACQ;
              good_cnt <= '0;
            end
          end else if (timeout_hit) begin
            to_err   <= 1'b1;
            locked   <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            good_cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          cnt      <= '0;
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_period_mon.sv
// tb_flag_period_mon: scoreboard bench for flag_period_mon.
// A cycle-indexed reference model pushes expected outputs per driven cycle;
// they are popped and compared one edge later.
module tb_flag_period_mon;

  localparam int CNT_W      = 8;
  localparam int EXP_PERIOD = 4;
  localparam int LOCK_CNT   = 3;
  localparam int TIMEOUT    = 8;

  logic             clk;
  logic             rst;
  logic             pi_flag;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             locked;
  logic             err;
  logic             to_err;

  flag_period_mon #(
    .CNT_W     (CNT_W),
    .EXP_PERIOD(EXP_PERIOD),
    .LOCK_CNT  (LOCK_CNT),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pi_flag   (pi_flag),
    .period    (period),
    .period_vld(period_vld),
    .locked    (locked),
    .err       (err),
    .to_err    (to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int vld;
    int er;
    int to;
    int lk;
    int per;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: tracks the absolute cycle of the last flag.
  int m_state = 0;   // 0 idle, 1 acq, 2 lock
  int m_last  = 0;
  int m_good  = 0;
  int m_per   = 0;
  int cyc     = 0;

  task automatic check(input string tag, input int got, input int expv);
    n_tests++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, got, expv);
    end
  endtask

  task automatic model(input logic f);
    exp_t e;
    int gap;
    e.vld = 0; e.er = 0; e.to = 0;
    if (m_state == 0) begin
      if (f) begin
        m_state = 1;
        m_good  = 0;
        m_last  = cyc;
      end
    end else begin
      gap = cyc - m_last;
      if (f) begin
        e.vld  = 1;
        m_per  = gap;
        m_last = cyc;
        if (gap == EXP_PERIOD) begin
          if (m_state == 1) begin
            if (m_good + 1 == LOCK_CNT) begin
              m_state = 2;
              m_good  = 0;
            end else begin
              m_good++;
            end
          end
        end else begin
          e.er    = 1;
          m_good  = 0;
          m_state = 1;
        end
      end else if (gap == TIMEOUT) begin
        e.to    = 1;
        m_state = 0;
        m_good  = 0;
      end
    end
    e.lk  = (m_state == 2) ? 1 : 0;
    e.per = m_per;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic f);
    exp_t e;
    @(negedge clk);
    pi_flag = f;
    model(f);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("period_vld", int'(period_vld), e.vld);
      check("err",        int'(err),        e.er);
      check("to_err",     int'(to_err),     e.to);
      check("locked",     int'(locked),     e.lk);
      check("period",     int'(period),     e.per);
      check("err_and_to", int'(err & to_err), 0);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic flag_gap(input int g);
    idle(g - 1);
    step(1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"},     int'(period),     0);
    check({tag, "_period_vld"}, int'(period_vld), 0);
    check({tag, "_locked"},     int'(locked),     0);
    check({tag, "_err"},        int'(err),        0);
    check({tag, "_to_err"},     int'(to_err),     0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    pi_flag = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Nominal lock, then one further correct period in LOCK.
    step(1'b1);
    for (int i = 0; i < 4; i++) flag_gap(4);

    // Mismatch in LOCK, then relock with three correct periods.
    flag_gap(3);
    for (int i = 0; i < 3; i++) flag_gap(4);

    // Flags stop: timeout, then the next flag only re-arms.
    idle(12);
    step(1'b1);
    flag_gap(4);

    // Flag exactly at the timeout boundary is a mismatch, not a timeout.
    flag_gap(8);
    flag_gap(4);

    // Back-to-back flags: P=1 error, then three good periods to lock.
    flag_gap(1);
    for (int i = 0; i < 3; i++) flag_gap(4);
    idle(2);

    // Async reset pulsed between clock edges while locked.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    #1;
    rst = 1'b0;
    m_state = 0;
    m_good  = 0;
    m_per   = 0;
    cyc++;

    // Relock after reset; the first period_vld comes on the second flag.
    idle(2);
    step(1'b1);
    for (int i = 0; i < 3; i++) flag_gap(4);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
